dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the pipeline's data load/store port. Accepts one request per
//  access from the EX/MEM stage, services it after a fixed programmable latency and returns
//  read data with a one-cycle valid pulse. Drives stall_o to freeze PC, IF/ID, ID/EX and
//  EX/MEM while an access is outstanding. Replaces the zero-latency data memory.
// PARAMETERS
//  DEPTH  256  number of 32-bit words in the backing array (power of two)
//  LAT    2    wait cycles between acceptance and array access; legal range 1..15
//  AW     8    word-index width, equal to log2(DEPTH)
// PORTS
//  clk_i    in   1   clock; all state changes on the rising edge
//  rst_i    in   1   asynchronous, active-low reset
//  req_i    in   1   access request (EX/MEM MemRead | MemWrite)
//  we_i     in   1   1 = store, 0 = load; sampled with req_i
//  addr_i   in   32  byte address (EX/MEM ALU result)
//  wdata_i  in   32  store data
//  ready_o  out  1   responder is idle and can accept a request
//  stall_o  out  1   hold the upstream pipeline registers
//  rvalid_o out  1   one-cycle pulse: access complete; rdata_o is valid for loads
//  rdata_o  out  32  load data; holds the last value read
//  err_o    out  1   only when DMEM_ALIGN_CHK_EN is defined: misaligned-address pulse
// BEHAVIOUR
//  - Reset (rst_i=0, asynchronous): state=IDLE, counter=0, ready_o=1, stall_o=0,
//    rvalid_o=0, rdata_o=0, err_o=0. Array contents are not reset.
//  - FSM states: IDLE, WAIT, RESP.
//    IDLE: ready_o=1. If req_i=1, latch we/addr/wdata, load counter=LAT-1, go to WAIT.
//      stall_o=req_i, combinational in the same cycle.
//    WAIT: ready_o=0, stall_o=1. Counter decrements each cycle. When counter=0, access
//      the array on that edge (write if latched we=1, else capture the read into rdata_o)
//      and go to RESP.
//    RESP: rvalid_o=1, stall_o=0, ready_o=0; unconditionally return to IDLE.
//      req_i is ignored in RESP (it is still the completed instruction).
//  - Timing: a request accepted in cycle T holds stall_o high for T..T+LAT and asserts
//    rvalid_o in T+LAT+1. A request is serviced exactly once.
//  - Addressing: word index = addr_i[AW+1:2]. Higher bits are ignored, so out-of-range
//    addresses wrap modulo DEPTH.
//  - Stores leave rdata_o unchanged. A store followed by a load to the same word returns
//    the stored value.
//  - Back-to-back requests: the next request can be accepted in the IDLE cycle right after
//    RESP. There is no lost or duplicate access.
//  - Reset during WAIT abandons the access; a write not yet performed is not performed.
// CONFIGURATION
//  DMEM_ALIGN_CHK_EN defined: err_o is present. If the latched addr[1:0] != 0, the
//    access is suppressed (no write, rdata_o unchanged) and err_o pulses in the RESP
//    cycle together with rvalid_o. Timing is unchanged.
//  DMEM_ALIGN_CHK_EN undefined: no err_o port; addr_i[1:0] is ignored.
// STRUCTURE
//  - Shared package dmem_pkg holds:
//    - the state typedef {IDLE, WAIT, RESP};
//    - constants DATA_W=32 and CNT_W=4.
//  - Sub-module dmem_array:
//    - synchronous single-port RAM, DEPTH x 32;
//    - ports clk, en, we, idx[AW-1:0], wdata, rdata; registered read.
//  - FSM, counter and request latch live in dmem_responder.
// TESTING
//  - Reset: assert rst_i=0 mid-WAIT. Outputs return to their reset values immediately;
//    word 5 stays unchanged after the abandoned store of 0xDEAD to addr 0x14.
//  - Store then load, LAT=2: store 0x12345678 at addr 0x20 in cycle T. stall_o is high
//    T..T+2, rvalid_o pulses in T+3. The load at 0x20 then returns rdata_o=0x12345678
//    with its rvalid_o pulse.
//  - Back-to-back: load A, then load B with req_i held high. Exactly two rvalid_o pulses
//    occur, 4 cycles apart, with the correct data each time.
//  - Wrap: with DEPTH=256, store 0xA5A5A5A5 at addr 0x400. A load at addr 0x000 returns
//    0xA5A5A5A5.
//  - LAT=1: request in T gives stall_o high T..T+1 and rvalid_o in T+2.
//  - DMEM_ALIGN_CHK_EN: store to addr 0x22 gives err_o=1 and rvalid_o=1 in the same
//    cycle; a later load at 0x20 returns the old value.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Imported by dmem_responder and dmem_array.
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with a registered read port.
// The read register only updates on reads, so stores leave it intact.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                r_mem[idx] <= wdata;
            end else begin
                rdata <= r_mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with pipeline stall and rvalid pulse.
// Optional misaligned-access detection when DMEM_ALIGN_CHK_EN is defined.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int LAT   = 2,
    parameter int AW    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              ready_o,
    output logic              stall_o,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o
`ifdef DMEM_ALIGN_CHK_EN
    ,
    output logic              err_o
`endif
);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [AW-1:0]     r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_ld;
    logic              w_go;
    logic              w_ok;
    logic              w_en;
    logic [DATA_W-1:0] w_rdata;
    logic              w_unused;

    assign w_unused = &{1'b0, addr_i[31:AW+2], addr_i[1:0]};

`ifdef DMEM_ALIGN_CHK_EN
    logic r_mis;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mis <= 1'b0;
        end else if (r_state == IDLE && req_i) begin
            r_mis <= (addr_i[1:0] != 2'b00);
        end
    end

    assign w_ok  = ~r_mis;
    assign err_o = (r_state == RESP) & r_mis;
`else
    assign w_ok = 1'b1;
`endif

    assign w_go = (r_state == WAIT) && (r_cnt == '0);
    assign w_en = w_go & w_ok;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk_i),
        .en    (w_en),
        .we    (r_we),
        .idx   (r_idx),
        .wdata (r_wdata),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ld    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (req_i) begin
                        r_we    <= we_i;
                        r_idx   <= addr_i[AW+1:2];
                        r_wdata <= wdata_i;
                        r_cnt   <= CNT_W'(LAT - 1);
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_ld    <= w_en & ~r_we;
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    // RAM output is live this cycle; keep a copy for later.
                    if (r_ld) begin
                        r_rdata <= w_rdata;
                    end
                    r_ld    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready_o  = (r_state == IDLE);
    assign stall_o  = ((r_state == IDLE) & req_i) | (r_state == WAIT);
    assign rvalid_o = (r_state == RESP);
    assign rdata_o  = r_ld ? w_rdata : r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder at LAT=2 (u0) and LAT=1 (u1).
// Define DMEM_ALIGN_CHK_EN to also exercise the misaligned-store path.
module tb_dmem_responder;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req;
    logic [1:0]       we;
    logic [1:0][31:0] addr;
    logic [1:0][31:0] wdata;
    logic [1:0]       ready;
    logic [1:0]       stall;
    logic [1:0]       rvalid;
    logic [1:0][31:0] rdata;
`ifdef DMEM_ALIGN_CHK_EN
    logic [1:0]       err;
`endif

    int checks = 0;
    int errors = 0;
    int lat [2] = '{2, 1};
    logic [31:0] mdl [2][256];
    logic [31:0] lastr [2];
    logic [31:0] sb [$];

    dmem_responder #(.DEPTH(256), .LAT(2), .AW(8)) u0 (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .req_i    (req[0]),
        .we_i     (we[0]),
        .addr_i   (addr[0]),
        .wdata_i  (wdata[0]),
        .ready_o  (ready[0]),
        .stall_o  (stall[0]),
        .rvalid_o (rvalid[0]),
        .rdata_o  (rdata[0])
`ifdef DMEM_ALIGN_CHK_EN
        ,
        .err_o    (err[0])
`endif
    );

    dmem_responder #(.DEPTH(256), .LAT(1), .AW(8)) u1 (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .req_i    (req[1]),
        .we_i     (we[1]),
        .addr_i   (addr[1]),
        .wdata_i  (wdata[1]),
        .ready_o  (ready[1]),
        .stall_o  (stall[1]),
        .rvalid_o (rvalid[1]),
        .rdata_o  (rdata[1])
`ifdef DMEM_ALIGN_CHK_EN
        ,
        .err_o    (err[1])
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete access; caller and return both sit on a falling edge.
    task automatic access(input int d, input logic w,
                          input logic [31:0] a, input logic [31:0] wd);
        int n;
        logic bad;
        logic [31:0] exp;
        bad = 1'b0;
`ifdef DMEM_ALIGN_CHK_EN
        bad = (a[1:0] != 2'b00);
`endif
        if (!w) begin
            exp = bad ? lastr[d] : mdl[d][a[9:2]];
            sb.push_back(exp);
        end
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        #1;
        chk("stall_accept", 32'(stall[d]), 32'd1);
        chk("ready_accept", 32'(ready[d]), 32'd1);
        @(negedge clk);
        req[d] = 1'b0;
        n = 1;
        while (!rvalid[d] && n < 20) begin
            chk("stall_wait", 32'(stall[d]), 32'd1);
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(lat[d] + 1));
        chk("stall_resp", 32'(stall[d]), 32'd0);
        chk("ready_resp", 32'(ready[d]), 32'd0);
        if (!w) begin
            exp = sb.pop_front();
            chk("rdata_load", rdata[d], exp);
            lastr[d] = exp;
        end else begin
            chk("rdata_store_hold", rdata[d], lastr[d]);
            if (!bad) mdl[d][a[9:2]] = wd;
        end
`ifdef DMEM_ALIGN_CHK_EN
        chk("err_resp", 32'(err[d]), 32'(bad));
`endif
        @(negedge clk);
        chk("rvalid_pulse_end", 32'(rvalid[d]), 32'd0);
        chk("ready_idle", 32'(ready[d]), 32'd1);
        chk("rdata_hold", rdata[d], lastr[d]);
    endtask

    initial begin
        int pulses;
        int t0;
        int t1;
        logic [31:0] exp;
        clk = 1'b0;
        rst_n = 1'b0;
        req = '0; we = '0; addr = '0; wdata = '0;
        lastr[0] = '0; lastr[1] = '0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(ready[d]), 32'd1);
            chk("rst_stall", 32'(stall[d]), 32'd0);
            chk("rst_rvalid", 32'(rvalid[d]), 32'd0);
            chk("rst_rdata", rdata[d], 32'd0);
`ifdef DMEM_ALIGN_CHK_EN
            chk("rst_err", 32'(err[d]), 32'd0);
`endif
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of a store abandons it.
        access(0, 1'b1, 32'h14, 32'h0BADF00D);
        access(0, 1'b0, 32'h14, 32'h0);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h14; wdata[0] = 32'hDEAD;
        @(negedge clk);
        req[0] = 1'b0;
        chk("abandon_in_wait", 32'(stall[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_ready", 32'(ready[0]), 32'd1);
        chk("rst_async_stall", 32'(stall[0]), 32'd0);
        chk("rst_async_rvalid", 32'(rvalid[0]), 32'd0);
        chk("rst_async_rdata", rdata[0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lastr[0] = '0; lastr[1] = '0;
        @(negedge clk);
        access(0, 1'b0, 32'h14, 32'h0);

        access(0, 1'b1, 32'h20, 32'h12345678);
        access(0, 1'b0, 32'h20, 32'h0);

        // Back-to-back loads with req_i held high.
        access(0, 1'b1, 32'h30, 32'h11112222);
        access(0, 1'b1, 32'h34, 32'h33334444);
        sb.push_back(mdl[0][8'h0C]);
        sb.push_back(mdl[0][8'h0D]);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h30;
        pulses = 0; t0 = -1; t1 = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) addr[0] = 32'h34;
            if (k == 5) req[0] = 1'b0;
            if (rvalid[0]) begin
                pulses++;
                if (t0 < 0) t0 = k; else t1 = k;
                if (sb.size() > 0) begin
                    exp = sb.pop_front();
                    chk("b2b_rdata", rdata[0], exp);
                    lastr[0] = exp;
                end
            end
        end
        chk("b2b_pulses", 32'(pulses), 32'd2);
        chk("b2b_first", 32'(t0), 32'd3);
        chk("b2b_spacing", 32'(t1 - t0), 32'd4);
        sb.delete();

        // Index wraps modulo DEPTH.
        access(0, 1'b1, 32'h400, 32'hA5A5A5A5);
        access(0, 1'b0, 32'h000, 32'h0);

        access(1, 1'b1, 32'h8, 32'hCAFEBABE);
        access(1, 1'b0, 32'h8, 32'h0);

`ifdef DMEM_ALIGN_CHK_EN
        access(0, 1'b1, 32'h22, 32'hFFFFFFFF);
        access(0, 1'b0, 32'h20, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
